ioctl_download_initiator: RTL and testbench
===========================================

Name: ioctl_download_initiator

Overview:
- Drives the HPS-side end of the 16-bit (WIDE) ioctl download interface: ioctl_download, ioctl_index, ioctl_wr, ioctl_addr and ioctl_dout, honouring the core's ioctl_wait back-pressure.
- Pulls words from a valid/ready source stream.
- Used in the simulation harness and in the on-FPGA self-test ROM loader, so the core's download path can run without the HPS.

Parameters:
- SETUP_CYCLES, 2: cycles ioctl_download is high before the first write.
- WR_GAP, 3: minimum idle cycles between consecutive ioctl_wr pulses (range 0..15).
- TAIL_CYCLES, 4: cycles ioctl_download stays high after the last write.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  stop issuing writes and terminate the transfer.
- index  in  8  ROM index; latched on start.
- len  in  26  transfer length in 16-bit words; latched on start.
- src_valid  in  1  source word available.
- src_data  in  16  source word.
- src_ready  out  1  source handshake; word consumed when src_valid&src_ready.
- ioctl_download  out  1  download active.
- ioctl_index  out  8  latched index.
- ioctl_wr  out  1  single-cycle write strobe.
- ioctl_addr  out  27  byte address of the current word.
- ioctl_dout  out  16  write data.
- ioctl_wait  in  1  core back-pressure, active high.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  single-cycle pulse at transfer end.

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs reset to 0: download, index, wr, addr, dout, src_ready, busy, done. State resets to IDLE.
- Reset asserted mid-transfer clears all outputs immediately; no done pulse is produced.
- All outputs are registered except src_ready, which is combinational from state and inputs.
- States:
  - IDLE: on start, latch index and len into remaining, clear addr, set download=1 and busy=1 next cycle, go to SETUP. start is ignored in all other states.
  - SETUP: count SETUP_CYCLES, then go to ISSUE. If remaining==0, go straight to TAIL instead.
  - ISSUE: issue condition is remaining!=0 && gap_cnt==0 && !ioctl_wait && src_valid && !abort.
    - When the condition holds: src_ready=1 that cycle; next cycle ioctl_wr=1 with ioctl_dout=src_data and ioctl_addr=current addr.
    - The cycle after the write strobe: addr += 2, remaining -= 1, gap_cnt = WR_GAP.
    - gap_cnt decrements to 0 each cycle while nonzero.
    - ioctl_wait or !src_valid simply stalls the block; a strobe already registered always completes.
    - After the last word's strobe, go to TAIL.
  - TAIL: hold download for TAIL_CYCLES. Then download=0, done=1 for one cycle, busy=0, go to IDLE.
- Address rule: ioctl_addr always holds an even byte address, with addr[0]=0.
- Maximum length is 2^26-1 words. The final address is below 2^27, so no wrap occurs.
- abort in SETUP or ISSUE: no further issue. Any registered strobe completes, then go to TAIL; done still pulses.
- abort in TAIL or IDLE has no effect.
- ioctl_wait rising in the same cycle an issue would occur blocks the issue (src_ready=0).
- ioctl_wait has no effect on SETUP or TAIL timing.
- ioctl_index holds its latched value until the next start.
- ioctl_dout and ioctl_addr hold their last values between strobes.

Test Plan:
- Basic transfer, defaults: start, index=0x00, len=4, src always valid with data 0x1111..0x4444.
  - Required: download rises the cycle after start.
  - First wr occurs 2 cycles later with addr=0, dout=0x1111.
  - Subsequent wr pulses are exactly 4 cycles apart at addr 2, 4, 6.
  - download falls 4 cycles after the addr=6 increment cycle; done is pulsed once.
- Wait stall: len=3; hold ioctl_wait high for 10 cycles after the first wr.
  - Required: no wr and no src_ready during the wait.
  - The second wr comes one cycle after wait falls; addresses are 0, 2, 4; data is unaltered.
- Source starvation: src_valid toggles every 5 cycles.
  - Required: each wr matches the consumed word in order; wr count equals len=5.
  - The gap between wr pulses is never below WR_GAP+1 cycles.
- Zero length: start with len=0.
  - Required: download high for SETUP_CYCLES+TAIL_CYCLES; zero wr pulses; src_ready never asserted; one done pulse.
- Abort: len=100, assert abort after the 3rd wr.
  - Required: at most the already-registered strobe follows; TAIL executes; done pulses; busy falls; a new start is accepted next.
- Reset mid-transfer: drop rst_n during ISSUE.
  - Required: all outputs read 0 in the same cycle; no done pulse.
  - After release, a new start with index=0x01 behaves exactly as in the basic transfer.

Source files
------------

// File: rtl/ioctl_download_initiator_if.sv
`default_nettype none
// ============================================================================
// Module  : ioctl_download_initiator_if
// Brief   : Bundles the 16-bit ioctl download bus and the valid/ready source
//           stream that feeds it.
// Revision: 1.0 - initial release
// ============================================================================
interface ioctl_download_initiator_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;

  // Initiator side: drives the ioctl bus, consumes the source stream.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output src_ready,
    input  ioctl_wait, src_valid, src_data
  );

  // Core/source side: receives the ioctl bus, supplies words and back-pressure.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  src_ready,
    output ioctl_wait, src_valid, src_data
  );
endinterface
`default_nettype wire

// File: rtl/ioctl_download_initiator.sv
`default_nettype none
// ============================================================================
// Module  : ioctl_download_initiator
// Brief   : HPS-side master of the 16-bit ioctl download port. Streams words
//           from a valid/ready source with set-up, inter-write gap and tail
//           timing, honouring ioctl_wait back-pressure and abort.
// Revision: 1.0 - initial release
// ============================================================================
module ioctl_download_initiator #(
  parameter int SETUP_CYCLES = 2,
  parameter int WR_GAP       = 3,
  parameter int TAIL_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  index,
  input  logic [25:0] len,
  output logic        busy,
  output logic        done,
  ioctl_download_initiator_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_TAIL  = 2'd3;

  // SETUP covers all set-up cycles but the last; the last one is spent in
  // ISSUE, where the first word can already be accepted so that its strobe
  // lands right after SETUP_CYCLES cycles of download.
  localparam logic [15:0] SETUP_LOAD  = (SETUP_CYCLES > 1) ? 16'(SETUP_CYCLES - 1) : 16'd1;
  localparam logic [1:0]  FIRST_STATE = (SETUP_CYCLES > 1) ? S_SETUP : S_ISSUE;
  localparam logic [15:0] TAIL_LOAD   = (TAIL_CYCLES > 0) ? 16'(TAIL_CYCLES - 1) : 16'd0;
  localparam logic [3:0]  GAP_LOAD    = 4'(WR_GAP);

  logic [1:0]  state;
  logic [15:0] setup_cnt;
  logic [15:0] tail_cnt;
  logic [3:0]  gap_cnt;
  logic [25:0] remaining;
  logic [26:0] next_addr;
  logic        download_q;
  logic [7:0]  index_q;
  logic        wr_q;
  logic [26:0] addr_q;
  logic [15:0] dout_q;
  logic        issue;

  // A word is taken when credit remains, the gap has expired, the core is
  // not stalling, the source has data and no abort is requested.
  assign issue = (state == S_ISSUE) && (remaining != 26'd0) && (gap_cnt == 4'd0)
              && !bus.ioctl_wait && bus.src_valid && !abort;

  assign bus.src_ready      = issue;
  assign bus.ioctl_download = download_q;
  assign bus.ioctl_index    = index_q;
  assign bus.ioctl_wr       = wr_q;
  assign bus.ioctl_addr     = addr_q;
  assign bus.ioctl_dout     = dout_q;

  // Transfer sequencing and all registered ioctl/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      setup_cnt  <= 16'd0;
      tail_cnt   <= 16'd0;
      gap_cnt    <= 4'd0;
      remaining  <= 26'd0;
      next_addr  <= 27'd0;
      download_q <= 1'b0;
      index_q    <= 8'd0;
      wr_q       <= 1'b0;
      addr_q     <= 27'd0;
      dout_q     <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      done <= 1'b0;
      if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            index_q    <= index;
            remaining  <= len;
            next_addr  <= 27'd0;
            addr_q     <= 27'd0;
            gap_cnt    <= 4'd0;
            setup_cnt  <= SETUP_LOAD;
            download_q <= 1'b1;
            busy       <= 1'b1;
            state      <= FIRST_STATE;
          end
        end

        S_SETUP: begin
          if (abort) begin
            tail_cnt <= TAIL_LOAD;
            state    <= S_TAIL;
          end else if (setup_cnt <= 16'd1) begin
            state <= S_ISSUE;
          end else begin
            setup_cnt <= setup_cnt - 16'd1;
          end
        end

        S_ISSUE: begin
          // Credit, address and gap move at the accept edge so a
          // back-to-back accept (WR_GAP=0) sees consistent values; the
          // strobe itself carries the address of the word just taken.
          if (issue) begin
            wr_q      <= 1'b1;
            dout_q    <= bus.src_data;
            addr_q    <= next_addr;
            next_addr <= next_addr + 27'd2;
            remaining <= remaining - 26'd1;
            gap_cnt   <= GAP_LOAD;
          end else if ((remaining == 26'd0) || abort) begin
            // Reached on the last word's strobe cycle, on abort, or at once
            // for a zero-length transfer (download then spans set-up + tail).
            tail_cnt <= TAIL_LOAD;
            state    <= S_TAIL;
          end
        end

        S_TAIL: begin
          if (tail_cnt == 16'd0) begin
            download_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_IDLE;
          end else begin
            tail_cnt <= tail_cnt - 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_download_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_ioctl_download_initiator
// Brief   : Self-checking bench: cycle-level behavioural model of the download
//           timeline plus directed scenarios with literal timing expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ioctl_download_initiator;
  localparam int SETUP = 2;
  localparam int GAP   = 3;
  localparam int TAIL  = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  index = 8'd0;
  logic [25:0] len   = 26'd0;
  logic        busy;
  logic        done;

  ioctl_download_initiator_if bus ();

  ioctl_download_initiator #(
    .SETUP_CYCLES(SETUP), .WR_GAP(GAP), .TAIL_CYCLES(TAIL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .index(index),
    .len(len), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event logs written by the compare process, read by directed scenarios.
  int          wr_log[$];
  logic [26:0] addr_log[$];
  logic [15:0] dout_log[$];
  int          done_log[$];
  int          fall_log[$];
  int          rise_log[$];
  int          rdy_cnt = 0;

  // Behavioural model: transfer timeline in cycles since start.
  int          m_phase = 0;   // 0 idle, 1 set-up/writing, 2 tail
  int          m_t0, m_left, m_nw, m_last, m_fall;
  bit          m_wr, m_done;
  logic [26:0] m_addr;
  logic [15:0] m_dout;
  logic [7:0]  m_index;
  bit          exp_rdy;
  logic        prev_dl = 1'b0;

  // Compare DUT against the model every cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_wr = 0; m_done = 0;
        m_addr = '0; m_dout = '0; m_index = '0;
        check("reset_ctrl", {27'd0, busy, done, bus.ioctl_download, bus.ioctl_wr, bus.src_ready}, 32'd0);
        check("reset_addr", bus.ioctl_addr, 32'd0);
        check("reset_data", {8'd0, bus.ioctl_index, bus.ioctl_dout}, 32'd0);
        prev_dl = 1'b0;
      end else begin
        exp_rdy = (m_phase == 1) && (cyc >= m_t0 + SETUP) && (m_left > 0)
               && (cyc - m_last > GAP) && !bus.ioctl_wait && bus.src_valid && !abort;
        check("busy",      busy,               m_phase != 0);
        check("download",  bus.ioctl_download, m_phase != 0);
        check("done",      done,               m_done);
        check("wr",        bus.ioctl_wr,       m_wr);
        check("addr",      bus.ioctl_addr,     m_addr);
        check("dout",      bus.ioctl_dout,     m_dout);
        check("index",     bus.ioctl_index,    m_index);
        check("src_ready", bus.src_ready,      exp_rdy);

        if (bus.ioctl_wr) begin
          wr_log.push_back(cyc);
          addr_log.push_back(bus.ioctl_addr);
          dout_log.push_back(bus.ioctl_dout);
        end
        if (done) done_log.push_back(cyc);
        if (prev_dl && !bus.ioctl_download) fall_log.push_back(cyc);
        if (!prev_dl && bus.ioctl_download) rise_log.push_back(cyc);
        if (bus.src_ready) rdy_cnt++;
        prev_dl = bus.ioctl_download;

        m_done = 0;
        m_wr   = 0;
        case (m_phase)
          0: if (start) begin
               m_phase = 1; m_t0 = cyc; m_left = int'(len); m_nw = 0;
               m_last = -1000; m_index = index; m_addr = '0;
             end
          1: if (exp_rdy) begin
               m_wr = 1; m_dout = bus.src_data; m_addr = 27'(2 * m_nw);
               m_nw++; m_left--; m_last = cyc;
             end else if (abort || (cyc >= m_t0 + SETUP && m_left == 0)) begin
               m_phase = 2; m_fall = cyc + TAIL + 1;
             end
          default: if (cyc + 1 == m_fall) begin
               m_phase = 0; m_done = 1;
             end
        endcase
      end
      cyc++;
    end
  end

  // Stimulus helpers.
  int cons = 0;
  bit seq  = 1'b1;

  // Advance one cycle; returns 1 ns after the next rising edge.
  task automatic step();
    bit took;
    @(negedge clk);
    took = bus.src_valid && bus.src_ready;
    if (took) cons++;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (seq) bus.src_data = 16'((cons + 1) * 16'h1111);
    else if (took) bus.src_data = 16'($urandom);
  endtask

  task automatic begin_xfer(input logic [7:0] idx, input int n);
    seq = 1'b1; cons = 0; bus.src_data = 16'h1111;
    start = 1'b1; index = idx; len = 26'(n);
  endtask

  logic [15:0] exp_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  task automatic basic_transfer(input logic [7:0] idx, input string tag);
    int w0, d0, f0, r0, ts;
    w0 = wr_log.size(); d0 = done_log.size(); f0 = fall_log.size(); r0 = rise_log.size();
    bus.src_valid = 1'b1; bus.ioctl_wait = 1'b0;
    ts = cyc;
    begin_xfer(idx, 4);
    repeat (26) step();
    check({tag, "_wr_count"}, wr_log.size() - w0, 4);
    check({tag, "_rise_count"}, rise_log.size() - r0, 1);
    if (rise_log.size() > r0) check({tag, "_rise_cycle"}, rise_log[r0] - ts, 1);
    for (int k = 0; k < 4; k++) begin
      if (wr_log.size() > w0 + k) begin
        check({tag, "_wr_cycle"}, wr_log[w0 + k] - ts, 3 + 4 * k);
        check({tag, "_wr_addr"}, addr_log[w0 + k], 2 * k);
        check({tag, "_wr_dout"}, dout_log[w0 + k], exp_d[k]);
      end
    end
    check({tag, "_done_count"}, done_log.size() - d0, 1);
    if (done_log.size() > d0) check({tag, "_done_cycle"}, done_log[d0] - ts, 20);
    if (fall_log.size() > f0) check({tag, "_fall_cycle"}, fall_log[f0] - ts, 20);
    else check({tag, "_fall_missing"}, 0, 1);
    check({tag, "_index_held"}, bus.ioctl_index, idx);
  endtask

  initial begin
    int w0, w1, d0, f0, r0, ts, n, mingap;
    bus.src_valid = 1'b0; bus.src_data = 16'h0; bus.ioctl_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_lit", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transfer.
    basic_transfer(8'h00, "basic");

    // Wait stall after the first write.
    w0 = wr_log.size(); d0 = done_log.size();
    bus.src_valid = 1'b1;
    begin_xfer(8'h02, 3);
    n = 0;
    while (wr_log.size() == w0 && n < 20) begin step(); n++; end
    if (wr_log.size() == w0) check("wait_first_wr_timeout", 0, 1);
    bus.ioctl_wait = 1'b1;
    w1 = wr_log.size(); r0 = rdy_cnt;
    repeat (10) step();
    check("wait_no_wr", wr_log.size() - w1, 0);
    check("wait_no_ready", rdy_cnt - r0, 0);
    bus.ioctl_wait = 1'b0;
    repeat (20) step();
    check("wait_wr_count", wr_log.size() - w0, 3);
    if (wr_log.size() >= w0 + 3) begin
      check("wait_second_spacing", wr_log[w0 + 1] - wr_log[w0], 12);
      for (int k = 0; k < 3; k++) begin
        check("wait_addr", addr_log[w0 + k], 2 * k);
        check("wait_dout", dout_log[w0 + k], exp_d[k]);
      end
    end
    check("wait_done_count", done_log.size() - d0, 1);

    // Source starvation: valid toggles every 5 cycles.
    w0 = wr_log.size(); d0 = done_log.size();
    begin_xfer(8'h03, 5);
    for (int i = 0; i < 90; i++) begin
      bus.src_valid = ((i / 5) % 2) == 0;
      step();
    end
    bus.src_valid = 1'b1;
    check("starve_wr_count", wr_log.size() - w0, 5);
    mingap = 1000;
    for (int k = 0; k < 5; k++) begin
      if (wr_log.size() > w0 + k) begin
        check("starve_dout_order", dout_log[w0 + k], 16'((k + 1) * 16'h1111));
        if (k > 0 && wr_log[w0 + k] - wr_log[w0 + k - 1] < mingap)
          mingap = wr_log[w0 + k] - wr_log[w0 + k - 1];
      end
    end
    check("starve_min_gap_ok", mingap >= GAP + 1, 1);
    check("starve_done_count", done_log.size() - d0, 1);

    // Zero length.
    w0 = wr_log.size(); d0 = done_log.size(); f0 = fall_log.size(); r0 = rdy_cnt;
    ts = cyc;
    begin_xfer(8'h04, 0);
    repeat (12) step();
    check("zero_wr_count", wr_log.size() - w0, 0);
    check("zero_ready_count", rdy_cnt - r0, 0);
    check("zero_done_count", done_log.size() - d0, 1);
    if (fall_log.size() > f0) check("zero_fall_cycle", fall_log[f0] - ts, SETUP + TAIL + 1);
    else check("zero_fall_missing", 0, 1);
    if (done_log.size() > d0) check("zero_done_cycle", done_log[d0] - ts, 7);

    // Abort after the third write, then a fresh start.
    w0 = wr_log.size(); d0 = done_log.size();
    begin_xfer(8'h05, 100);
    n = 0;
    while (wr_log.size() < w0 + 3 && n < 40) begin step(); n++; end
    if (wr_log.size() < w0 + 3) check("abort_third_wr_timeout", 0, 1);
    abort = 1'b1;
    step();
    repeat (12) step();
    check("abort_extra_wr_le1", (wr_log.size() - w0 - 3) <= 1, 1);
    check("abort_done_count", done_log.size() - d0, 1);
    check("abort_busy_low", busy, 0);
    w1 = wr_log.size();
    begin_xfer(8'h06, 1);
    repeat (12) step();
    check("abort_restart_wr", wr_log.size() - w1, 1);
    check("abort_restart_done", done_log.size() - d0, 2);

    // Reset in the middle of ISSUE.
    w0 = wr_log.size();
    begin_xfer(8'h5A, 4);
    n = 0;
    while (wr_log.size() == w0 && n < 20) begin step(); n++; end
    step();
    d0 = done_log.size();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_download", bus.ioctl_download, 0);
    check("rst_mid_index", bus.ioctl_index, 0);
    check("rst_mid_addr", bus.ioctl_addr, 0);
    check("rst_mid_ready", bus.src_ready, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8) step();
    check("rst_mid_no_done", done_log.size() - d0, 0);
    basic_transfer(8'h01, "post_rst");

    // Randomised traffic against the model.
    seq = 1'b0;
    bus.src_data = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      start         = ($urandom % 12) == 0;
      index         = 8'($urandom);
      len           = 26'($urandom % 7);
      bus.src_valid = ($urandom % 10) < 7;
      bus.ioctl_wait = ($urandom % 5) == 0;
      abort         = ($urandom % 60) == 0;
      step();
    end
    bus.src_valid = 1'b1; bus.ioctl_wait = 1'b0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case the sequence stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
